// File: rtl/imem_axi_rd_slave.sv
// Instruction-memory read responder for I-cache refill: one single-beat AR/R read
// at a time, served from a word store that is filled through a side load port.
//
// state  | meaning
// IDLE   | AR_READY high, waiting for an address handshake
// WAIT   | address latched, counting down the remaining read latency
// RESP   | R_VALID high, data/resp held until R_READY
`timescale 1ns/1ps
module imem_axi_rd_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    RD_LATENCY  = 1,
  parameter string                 INIT_FILE   = ""
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  AR_VALID,
  output logic                  AR_READY,
  input  logic [ADDR_WIDTH-1:0] AR_ADDR,
  output logic                  R_VALID,
  input  logic                  R_READY,
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic [1:0]            R_RESP,
  input  logic                  LOAD_WE,
  input  logic [ADDR_WIDTH-1:0] LOAD_ADDR,
  input  logic [DATA_WIDTH-1:0] LOAD_DATA,
  output logic [31:0]           RD_COUNT
);

  localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [DATA_WIDTH-1:0] NOP_WORD  = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIM = ADDR_WIDTH'(DEPTH_WORDS);
  localparam logic [3:0]            CNT_LOAD  = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ar_ready_q;
  logic                  r_valid_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [1:0]            r_resp_q;
  logic [31:0]           rd_count_q;
  logic                  ar_fire;
  logic                  enter_resp;
  logic                  r_done;

  logic [ADDR_WIDTH-1:0] rd_addr, rd_woff, ld_woff;
  logic                  rd_in_range, ld_in_range;
  logic [IDX_W-1:0]      rd_idx, ld_idx;

  // Subtraction wraps for addresses below BASE_ADDR, so they land out of range.
  assign rd_addr     = (state_q == ST_IDLE) ? AR_ADDR : addr_q;
  assign rd_woff     = (rd_addr - BASE_ADDR) >> 2;
  assign rd_in_range = rd_woff < DEPTH_LIM;
  assign rd_idx      = rd_woff[IDX_W-1:0];

  assign ld_woff     = (LOAD_ADDR - BASE_ADDR) >> 2;
  assign ld_in_range = ld_woff < DEPTH_LIM;
  assign ld_idx      = ld_woff[IDX_W-1:0];

  assign ar_fire = (state_q == ST_IDLE) && AR_VALID && ar_ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    r_done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ar_fire) begin
          if (RD_LATENCY == 1) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d    = ST_RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (R_READY) begin
          state_d = ST_IDLE;
          r_done  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory is read here on the edge entering RESP, before any same-edge load write lands.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= 2'b00;
      rd_count_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ar_ready_q <= (state_d == ST_IDLE);
      r_valid_q  <= (state_d == ST_RESP);
      if (ar_fire) begin
        addr_q <= AR_ADDR;
      end
      if (enter_resp) begin
        r_data_q <= rd_in_range ? mem[rd_idx] : NOP_WORD;
        r_resp_q <= rd_in_range ? 2'b00 : 2'b10;
      end
      if (r_done) begin
        rd_count_q <= rd_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (LOAD_WE && !ARESET && ld_in_range) begin
      mem[ld_idx] <= LOAD_DATA;
    end
  end

  assign AR_READY = ar_ready_q;
  assign R_VALID  = r_valid_q;
  assign R_DATA   = r_data_q;
  assign R_RESP   = r_resp_q;
  assign RD_COUNT = rd_count_q;

endmodule

// File: tb/tb_imem_axi_rd_slave.sv
// Bench for imem_axi_rd_slave: two instances (latency 1 at base 0, latency 4 at a
// nonzero base) driven with directed and random traffic against an array model.
`timescale 1ns/1ps
module tb_imem_axi_rd_slave;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic        ACLK = 1'b0;
  logic [1:0]  areset;
  logic [1:0]  ar_valid, ar_ready, r_valid, r_ready, load_we;
  logic [31:0] ar_addr   [2];
  logic [31:0] load_addr [2];
  logic [31:0] load_data [2];
  logic [31:0] r_data    [2];
  logic [31:0] rd_count  [2];
  logic [1:0]  r_resp    [2];

  always #5 ACLK = ~ACLK;

  imem_axi_rd_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(32'h0000_0000), .RD_LATENCY(1), .INIT_FILE("")
  ) dut0 (
    .ACLK(ACLK), .ARESET(areset[0]),
    .AR_VALID(ar_valid[0]), .AR_READY(ar_ready[0]), .AR_ADDR(ar_addr[0]),
    .R_VALID(r_valid[0]), .R_READY(r_ready[0]), .R_DATA(r_data[0]), .R_RESP(r_resp[0]),
    .LOAD_WE(load_we[0]), .LOAD_ADDR(load_addr[0]), .LOAD_DATA(load_data[0]),
    .RD_COUNT(rd_count[0])
  );

  imem_axi_rd_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(BASE1), .RD_LATENCY(4), .INIT_FILE("")
  ) dut1 (
    .ACLK(ACLK), .ARESET(areset[1]),
    .AR_VALID(ar_valid[1]), .AR_READY(ar_ready[1]), .AR_ADDR(ar_addr[1]),
    .R_VALID(r_valid[1]), .R_READY(r_ready[1]), .R_DATA(r_data[1]), .R_RESP(r_resp[1]),
    .LOAD_WE(load_we[1]), .LOAD_ADDR(load_addr[1]), .LOAD_DATA(load_data[1]),
    .RD_COUNT(rd_count[1])
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] mdl_mem [2][DEPTH];
  int          mdl_cnt [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 0) ? 32'h0 : BASE1;
  endfunction

  // Word index of a byte address, or -1 when it falls outside the store.
  function automatic longint word_of(input int i, input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(base_of(i));
    if (off >= 0 && off < 4 * DEPTH) return off / 4;
    return -1;
  endfunction

  task automatic model_load(input int i, input logic [31:0] a, input logic [31:0] d);
    longint w;
    w = word_of(i, a);
    if (w >= 0) mdl_mem[i][w] = d;
  endtask

  task automatic do_load(input int i, input logic [31:0] a, input logic [31:0] d);
    load_we[i] = 1'b1; load_addr[i] = a; load_data[i] = d;
    @(negedge ACLK);
    load_we[i] = 1'b0;
    model_load(i, a, d);
  endtask

  // One read; bp = cycles of R_READY low after R_VALID; coll = load the same
  // address on the edge that captures the read data.
  task automatic do_read(input int i, input logic [31:0] addr, input int bp,
                         input bit coll, input logic [31:0] cdata, input string tag);
    logic [31:0] ed;
    logic [1:0]  er;
    longint      w;
    int          lat, wt;
    w = word_of(i, addr);
    if (w >= 0) begin ed = mdl_mem[i][w]; er = 2'b00; end
    else        begin ed = 32'h0000_0013; er = 2'b10; end
    wt = 0;
    while (ar_ready[i] !== 1'b1 && wt < 20) begin @(negedge ACLK); wt++; end
    chk({tag, " ar_ready idle"}, 32'(ar_ready[i]), 32'd1);
    ar_valid[i] = 1'b1; ar_addr[i] = addr; r_ready[i] = (bp == 0);
    if (coll && lat_of(i) == 1) begin
      load_we[i] = 1'b1; load_addr[i] = addr; load_data[i] = cdata;
    end
    @(negedge ACLK);
    load_we[i] = 1'b0;
    ar_addr[i] = $urandom;
    lat = 1;
    while (r_valid[i] !== 1'b1 && lat < 40) begin
      chk({tag, " ar_ready busy"}, 32'(ar_ready[i]), 32'd0);
      if (coll && lat == lat_of(i) - 1) begin
        load_we[i] = 1'b1; load_addr[i] = addr; load_data[i] = cdata;
      end
      @(negedge ACLK);
      load_we[i] = 1'b0;
      lat++;
    end
    if (coll) model_load(i, addr, cdata);
    chk({tag, " latency"}, 32'(lat), 32'(lat_of(i)));
    for (int c = 0; c < bp; c++) begin
      chk({tag, " data held"}, r_data[i], ed);
      chk({tag, " ar_ready resp"}, 32'(ar_ready[i]), 32'd0);
      @(negedge ACLK);
    end
    chk({tag, " r_valid"}, 32'(r_valid[i]), 32'd1);
    chk({tag, " r_data"}, r_data[i], ed);
    chk({tag, " r_resp"}, 32'(r_resp[i]), 32'(er));
    r_ready[i] = 1'b1; ar_valid[i] = 1'b0;
    @(negedge ACLK);
    r_ready[i] = 1'b0;
    mdl_cnt[i]++;
    chk({tag, " r_valid done"}, 32'(r_valid[i]), 32'd0);
    chk({tag, " ar_ready done"}, 32'(ar_ready[i]), 32'd1);
    chk({tag, " rd_count"}, rd_count[i], 32'(mdl_cnt[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          i, op, bp, wt;
    logic [31:0] a, d;
    areset = 2'b11; ar_valid = '0; r_ready = '0; load_we = '0;
    for (int k = 0; k < 2; k++) begin
      ar_addr[k] = '0; load_addr[k] = '0; load_data[k] = '0; mdl_cnt[k] = 0;
    end

    // Reset and idle
    repeat (3) @(negedge ACLK);
    for (int k = 0; k < 2; k++) begin
      chk("rst ar_ready", 32'(ar_ready[k]), 32'd0);
      chk("rst r_valid", 32'(r_valid[k]), 32'd0);
      chk("rst r_data", r_data[k], 32'd0);
      chk("rst r_resp", 32'(r_resp[k]), 32'd0);
      chk("rst rd_count", rd_count[k], 32'd0);
    end
    areset = 2'b00;
    #1;
    chk("release ar_ready pre-edge", 32'(ar_ready), 32'd0);
    @(negedge ACLK);
    chk("release ar_ready", 32'(ar_ready), 32'd3);
    repeat (3) begin
      @(negedge ACLK);
      chk("idle r_valid", 32'(r_valid), 32'd0);
    end

    // Basic read, latency 1
    do_load(0, 32'h0000_0004, 32'hDEAD_BEEF);
    do_read(0, 32'h0000_0004, 0, 1'b0, '0, "basic");

    // Eight-word refill
    for (int k = 0; k < 8; k++) do_load(0, 32'h20 + 32'(4 * k), 32'h100 + 32'(k));
    for (int k = 0; k < 8; k++) do_read(0, 32'h20 + 32'(4 * k), 0, 1'b0, '0, "refill");

    // Latency 4 with backpressure
    do_load(1, BASE1 + 32'h40, 32'hCAFE_F00D);
    do_load(1, BASE1 + 32'h08, 32'h1234_5678);
    do_read(1, BASE1 + 32'h40, 5, 1'b0, '0, "bp_lat4");

    // Out of range, above the store and below the base
    do_read(0, 32'(4 * DEPTH), 1, 1'b0, '0, "oor0");
    do_read(1, BASE1 + 32'(4 * DEPTH), 2, 1'b0, '0, "oor1_hi");
    do_read(1, BASE1 - 32'd4, 0, 1'b0, '0, "oor1_lo");

    // Same-edge load collision returns the old word; the next read sees the new one
    do_load(0, 32'h50, 32'hAAAA_0001);
    do_read(0, 32'h50, 0, 1'b1, 32'hBBBB_0002, "coll0");
    do_read(0, 32'h50, 0, 1'b0, '0, "coll0 next");
    do_load(1, BASE1 + 32'h50, 32'hAAAA_0003);
    do_read(1, BASE1 + 32'h50, 1, 1'b1, 32'hBBBB_0004, "coll1");
    do_read(1, BASE1 + 32'h50, 0, 1'b0, '0, "coll1 next");

    // Reset pulse during WAIT discards the pending read
    wt = 0;
    while (ar_ready[1] !== 1'b1 && wt < 20) begin @(negedge ACLK); wt++; end
    ar_valid[1] = 1'b1; ar_addr[1] = BASE1 + 32'h08;
    @(negedge ACLK);
    ar_valid[1] = 1'b0;
    @(negedge ACLK);
    areset[1] = 1'b1;
    #1;
    chk("midrst r_valid", 32'(r_valid[1]), 32'd0);
    chk("midrst ar_ready", 32'(ar_ready[1]), 32'd0);
    chk("midrst rd_count", rd_count[1], 32'd0);
    @(negedge ACLK);
    areset[1] = 1'b0;
    mdl_cnt[1] = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge ACLK);
      chk("midrst no r_valid", 32'(r_valid[1]), 32'd0);
    end
    do_read(1, BASE1 + 32'h08, 0, 1'b0, '0, "post_rst");

    // Fill both stores, then random traffic
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < DEPTH; w++) do_load(k, base_of(k) + 32'(4 * w), $urandom);

    for (int n = 0; n < 80; n++) begin
      i  = int'($urandom_range(1, 0));
      op = int'($urandom_range(4, 0));
      bp = int'($urandom_range(3, 0));
      a  = base_of(i) + 32'(4 * $urandom_range(DEPTH - 1, 0));
      case (op)
        0, 1: do_read(i, a + 32'($urandom_range(3, 0)), bp, 1'b0, '0, "rnd_rd");
        2: begin
          if (i == 1 && $urandom_range(1, 0) == 1) d = 32'($urandom_range(BASE1 - 1, 0));
          else d = base_of(i) + 32'(4 * DEPTH) + 32'(4 * $urandom_range(1000, 0));
          do_read(i, d, bp, 1'b0, '0, "rnd_oor");
        end
        3: begin
          do_load(i, a, $urandom);
          do_read(i, a, bp, 1'b0, '0, "rnd_ld_rd");
        end
        default: begin
          do_load(i, a + 32'(4 * DEPTH), $urandom);
          do_read(i, a, bp, 1'b0, '0, "rnd_oor_ld");
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
